stream_demux: RTL and testbench

- Registered, valid/ready-handshaked successor of the combinational demux.
- Routes one input beat to one selected output channel, or broadcasts it to all channels.
- Each output channel has a 1-entry output register, so full throughput is sustained per channel.
- Used between the issue/dispatch logic and multiple functional-unit or writeback consumers.
- Out-of-range selects are consumed and dropped, flagged by a sticky error and a saturating drop counter.

---
 rtl/stream_demux.sv | 121 ++++++++++++
 tb/tb_stream_demux.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// Registered valid/ready demux: routes or broadcasts one input beat into
// per-channel 1-entry output registers; out-of-range selects are dropped and counted.

module stream_demux_chan #(
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o
);

  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] data_q, data_d;

  // A load wins over a drain, so drain+reload keeps valid high at full rate.
  always_comb begin
    valid_d = load_i | (valid_q & ~ready_i);
    data_d  = load_i ? data_i : data_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

module stream_demux #(
  parameter  int DataWidth  = 32,
  parameter  int NumOutputs = 8,
  parameter  int CntWidth   = 8,
  localparam int SelWidth   = (NumOutputs > 1) ? $clog2(NumOutputs) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DataWidth-1:0]  data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [SelWidth-1:0]   sel_i,
  input  logic                  bcast_i,
  output logic [DataWidth-1:0]  data_o [NumOutputs],
  output logic [NumOutputs-1:0] valid_o,
  input  logic [NumOutputs-1:0] ready_i,
  output logic                  err_o,
  input  logic                  clear_err_i,
  output logic [CntWidth-1:0]   drop_cnt_o
);

  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

  logic [NumOutputs-1:0] mask, free, load;
  logic                  accept, drop;
  logic                  err_q, err_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;

  // An out-of-range sel matches no channel, which yields the all-zero drop mask.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NumOutputs; i++) begin
      mask[i] = bcast_i | (sel_i == SelWidth'(i));
    end
  end

  // ready_o depends on ready_i combinationally but never on valid_i.
  assign free    = ~valid_o | ready_i;
  assign ready_o = &(~mask | free);
  assign accept  = valid_i & ready_o;
  assign load    = {NumOutputs{accept}} & mask;
  assign drop    = accept & (mask == '0);

  for (genvar g = 0; g < NumOutputs; g++) begin : g_chan
    stream_demux_chan #(.DataWidth(DataWidth)) u_chan (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load[g]),
      .data_i  (data_i),
      .ready_i (ready_i[g]),
      .valid_o (valid_o[g]),
      .data_o  (data_o[g])
    );
  end

  // Clear has priority over a same-cycle drop; the counter saturates.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (clear_err_i) begin
      err_d = 1'b0;
      cnt_d = '0;
    end else if (drop) begin
      err_d = 1'b1;
      if (cnt_q != CntMax) cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_o      = err_q;
  assign drop_cnt_o = cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: an 8-channel instance (routing, backpressure,
// broadcast, async reset) and a 6-channel instance (out-of-range drop path).

module tb_stream_demux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-channel instance
  logic [31:0] a_data_i = '0;
  logic        a_valid_i = 1'b0, a_bcast_i = 1'b0, a_clear = 1'b0;
  logic [2:0]  a_sel_i = '0;
  logic        a_ready_o, a_err_o;
  logic [31:0] a_data_o [8];
  logic [7:0]  a_valid_o;
  logic [7:0]  a_ready_i = '1;
  logic [7:0]  a_cnt_o;

  // 6-channel instance
  logic [31:0] b_data_i = '0;
  logic        b_valid_i = 1'b0, b_bcast_i = 1'b0, b_clear = 1'b0;
  logic [2:0]  b_sel_i = '0;
  logic        b_ready_o, b_err_o;
  logic [31:0] b_data_o [6];
  logic [5:0]  b_valid_o;
  logic [5:0]  b_ready_i = '1;
  logic [7:0]  b_cnt_o;

  stream_demux #(.DataWidth(32), .NumOutputs(8), .CntWidth(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(a_data_i), .valid_i(a_valid_i),
    .ready_o(a_ready_o), .sel_i(a_sel_i), .bcast_i(a_bcast_i), .data_o(a_data_o),
    .valid_o(a_valid_o), .ready_i(a_ready_i), .err_o(a_err_o),
    .clear_err_i(a_clear), .drop_cnt_o(a_cnt_o)
  );

  stream_demux #(.DataWidth(32), .NumOutputs(6), .CntWidth(8)) dut6 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(b_data_i), .valid_i(b_valid_i),
    .ready_o(b_ready_o), .sel_i(b_sel_i), .bcast_i(b_bcast_i), .data_o(b_data_o),
    .valid_o(b_valid_o), .ready_i(b_ready_i), .err_o(b_err_o),
    .clear_err_i(b_clear), .drop_cnt_o(b_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_valid8", 64'(a_valid_o), 64'h0);
    chk("rst_data8_0", 64'(a_data_o[0]), 64'h0);
    chk("rst_err8", 64'(a_err_o), 64'h0);
    chk("rst_cnt8", 64'(a_cnt_o), 64'h0);
    chk("rst_valid6", 64'(b_valid_o), 64'h0);
    #4 rst_n = 1'b1;
    tick();

    // Unicast, all ready: one beat per cycle, 1-cycle latency
    for (int k = 0; k < 8; k++) begin
      a_valid_i = 1'b1;
      a_sel_i   = 3'(k);
      a_data_i  = 32'hA5A5_0000 + 32'(k);
      #1 chk($sformatf("uni_ready_%0d", k), 64'(a_ready_o), 64'h1);
      tick();
      chk($sformatf("uni_valid_%0d", k), 64'(a_valid_o), 64'(8'h1 << k));
      chk($sformatf("uni_data_%0d", k), 64'(a_data_o[k]), 64'hA5A5_0000 + 64'(k));
    end
    a_valid_i = 1'b0;
    tick();
    chk("uni_drained", 64'(a_valid_o), 64'h0);

    // Backpressure on channel 3
    a_ready_i = 8'hF7;
    a_valid_i = 1'b1; a_sel_i = 3'd3; a_data_i = 32'h11;
    #1 chk("bp_ready1", 64'(a_ready_o), 64'h1);
    tick();
    chk("bp_valid1", 64'(a_valid_o), 64'h08);
    chk("bp_data1", 64'(a_data_o[3]), 64'h11);
    a_data_i = 32'h22;
    #1 chk("bp_ready2_stall", 64'(a_ready_o), 64'h0);
    tick();
    chk("bp_hold_valid", 64'(a_valid_o), 64'h08);
    chk("bp_hold_data", 64'(a_data_o[3]), 64'h11);
    a_ready_i = 8'hFF;
    #1 chk("bp_ready2_go", 64'(a_ready_o), 64'h1);
    tick();
    chk("bp_reload_valid", 64'(a_valid_o), 64'h08);
    chk("bp_reload_data", 64'(a_data_o[3]), 64'h22);
    a_valid_i = 1'b0;
    tick();
    chk("bp_drained", 64'(a_valid_o), 64'h0);

    // Broadcast stalls until every channel is free
    a_ready_i = 8'hDF;
    a_valid_i = 1'b1; a_sel_i = 3'd5; a_data_i = 32'h55;
    tick();
    chk("bc_pre_valid", 64'(a_valid_o), 64'h20);
    a_bcast_i = 1'b1; a_sel_i = 3'd0; a_data_i = 32'hDEAD;
    #1 chk("bc_stall_ready", 64'(a_ready_o), 64'h0);
    tick();
    chk("bc_stall_valid", 64'(a_valid_o), 64'h20);
    chk("bc_stall_data0", 64'(a_data_o[0]), 64'hA5A5_0000);
    chk("bc_stall_data5", 64'(a_data_o[5]), 64'h55);
    a_ready_i = 8'hFF;
    #1 chk("bc_go_ready", 64'(a_ready_o), 64'h1);
    tick();
    chk("bc_valid_all", 64'(a_valid_o), 64'hFF);
    chk("bc_data0", 64'(a_data_o[0]), 64'hDEAD);
    chk("bc_data5", 64'(a_data_o[5]), 64'hDEAD);
    chk("bc_data7", 64'(a_data_o[7]), 64'hDEAD);

    // Async reset mid-cycle while all channels hold beats
    a_valid_i = 1'b0; a_bcast_i = 1'b0; a_ready_i = 8'h00;
    #2 rst_n = 1'b0;
    #1 chk("arst_valid", 64'(a_valid_o), 64'h0);
    chk("arst_data7", 64'(a_data_o[7]), 64'h0);
    chk("arst_data3", 64'(a_data_o[3]), 64'h0);
    #3 rst_n = 1'b1;
    tick();
    a_ready_i = 8'hFF;
    a_valid_i = 1'b1; a_sel_i = 3'd2; a_data_i = 32'h77;
    #1 chk("arst_pre_valid", 64'(a_valid_o), 64'h0);
    tick();
    chk("arst_post_valid", 64'(a_valid_o), 64'h04);
    chk("arst_post_data", 64'(a_data_o[2]), 64'h77);
    a_valid_i = 1'b0;

    // Out-of-range drops on the 6-channel instance
    b_valid_i = 1'b1; b_sel_i = 3'd7; b_data_i = 32'hBAD;
    for (int k = 0; k < 300; k++) begin
      #1 chk($sformatf("oor_ready_%0d", k), 64'(b_ready_o), 64'h1);
      tick();
      chk($sformatf("oor_valid_%0d", k), 64'(b_valid_o), 64'h0);
      if (k == 0) begin
        chk("oor_err_first", 64'(b_err_o), 64'h1);
        chk("oor_cnt_first", 64'(b_cnt_o), 64'h1);
      end
    end
    chk("oor_cnt_sat", 64'(b_cnt_o), 64'd255);
    chk("oor_err_sticky", 64'(b_err_o), 64'h1);
    b_clear = 1'b1;
    tick();
    chk("clr_err", 64'(b_err_o), 64'h0);
    chk("clr_cnt", 64'(b_cnt_o), 64'h0);
    b_clear = 1'b0; b_sel_i = 3'd6;
    tick();
    chk("oor6_err", 64'(b_err_o), 64'h1);
    chk("oor6_cnt", 64'(b_cnt_o), 64'h1);
    b_sel_i = 3'd5; b_data_i = 32'h66;
    tick();
    chk("in6_valid", 64'(b_valid_o), 64'h20);
    chk("in6_data", 64'(b_data_o[5]), 64'h66);
    chk("in6_cnt", 64'(b_cnt_o), 64'h1);
    b_valid_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
